// File: rtl/multi_digit_disp.sv
// multi_digit_disp: serial double-dabble binary-to-BCD converter driving DIGITS active-low seven-segment digits
module multi_digit_disp #(
  parameter int WIDTH    = 8,
  parameter int DIGITS   = 3,
  parameter int BLANK_LZ = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [WIDTH-1:0]      value_in,
  input  logic                  load,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [7*DIGITS-1:0]   seg_out
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam int unsigned LIM = 10 ** DIGITS;
  localparam bit CAN_OVF = (64'd1 << WIDTH) > 64'(LIM);
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] DASH  = 7'b0111111;
  localparam logic [6:0] SEG [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                      7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  typedef enum logic [1:0] {IDLE, CONVERT, UPDATE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] bin;
  logic [BW-1:0] bcd, adj;
  logic [BW+WIDTH-1:0] sh;
  logic [CW-1:0] cnt;
  logic ovf_q, lead;
  logic [7*DIGITS-1:0] seg_n;
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state == IDLE    ? (load ? CONVERT : IDLE) :
              state == CONVERT ? (cnt == CW'(WIDTH - 1) ? UPDATE : CONVERT) : IDLE;
  end
  // one double-dabble step: correct every nibble, then shift the whole {bcd,bin} left
  always_comb begin
    adj = bcd;
    for (int k = 0; k < DIGITS; k++)
      adj[4*k+:4] = bcd[4*k+:4] >= 4'd5 ? bcd[4*k+:4] + 4'd3 : bcd[4*k+:4];
    sh = {adj, bin} << 1;
  end
  // lead stays high while every digit from the top down to k is zero
  always_comb begin
    lead = 1'b1;
    seg_n = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      lead = lead & (bcd[4*k+:4] == 4'd0);
      seg_n[7*k+:7] = ovf_q ? DASH :
                      (BLANK_LZ != 0 && lead && k != 0) ? BLANK :
                      bcd[4*k+:4] > 4'd9 ? BLANK : SEG[bcd[4*k+:4]];
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      bin      <= '0;
      bcd      <= '0;
      cnt      <= '0;
      ovf_q    <= 1'b0;
      overflow <= 1'b0;
      done     <= 1'b0;
      seg_out  <= '1;
    end else begin
      done <= state == UPDATE;
      if (state == IDLE && load) begin
        bin   <= value_in;
        bcd   <= '0;
        cnt   <= '0;
        ovf_q <= CAN_OVF && (32'(value_in) >= LIM);
      end else if (state == CONVERT) begin
        bcd <= sh[BW+WIDTH-1:WIDTH];
        bin <= sh[WIDTH-1:0];
        cnt <= cnt + 1'b1;
      end
      if (state == UPDATE) begin
        seg_out  <= seg_n;
        overflow <= ovf_q;
      end
    end
endmodule

// File: doc/multi_digit_disp.md
MULTI_DIGIT_DISP -- requirements
Module: multi_digit_disp

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, setting the binary input width (legal 4..20).
REQ-002 The block SHALL have parameter DIGITS, default 3, setting the number of seven-segment digits driven (legal 1..6).
REQ-003 The block SHALL have parameter BLANK_LZ, default 1; 1 blanks leading zeros, 0 shows them.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-005 The block SHALL have port reset_n, input, 1 bit: asynchronous reset, active-low.
REQ-006 The block SHALL have port value_in, input, WIDTH bits: unsigned binary value to display.
REQ-007 The block SHALL have port load, input, 1 bit: request to convert value_in.
REQ-008 The block SHALL have port busy, output, 1 bit: high while a conversion is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse when the display has updated.
REQ-010 The block SHALL have port overflow, output, 1 bit: latched value exceeded DIGITS decimal digits.
REQ-011 The block SHALL have port seg_out, output, 7*DIGITS bits: active-low segments; digit k (k=0 is least significant) in bits [7k+6:7k], bit order {g,f,e,d,c,b,a}.

Function
REQ-012 The FSM SHALL have states IDLE, CONVERT and UPDATE.
REQ-013 In IDLE, load=1 SHALL capture value_in, clear the BCD shift register and iteration counter, and enter CONVERT on the next edge.
REQ-014 On capture, overflow_next SHALL be set if value_in >= 10**DIGITS; when 2**WIDTH <= 10**DIGITS this compare SHALL be constant 0.
REQ-015 CONVERT SHALL perform one shift-add-3 (double-dabble) iteration per cycle, for exactly WIDTH cycles, then enter UPDATE.
REQ-016 The shift-add-3 step SHALL add 3 to any BCD nibble >= 5 before shifting; the BCD register SHALL be 4*DIGITS bits wide, and overflowed high bits SHALL be discarded.
REQ-017 UPDATE SHALL register seg_out and overflow from the conversion result, pulse done high for that cycle only, and return to IDLE.
REQ-018 busy SHALL be high in CONVERT and UPDATE and low in IDLE.
REQ-019 With load asserted at edge 0, done SHALL be high in the cycle following edge WIDTH+1, and seg_out SHALL be valid in that same cycle.
REQ-020 load while busy=1 SHALL be ignored, with no queuing.
REQ-021 load held high continuously SHALL restart a conversion on the first IDLE cycle after done.
REQ-022 seg_out and overflow SHALL hold their previous values throughout CONVERT.
REQ-023 Digit encodings SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, blank=1111111, dash=0111111.
REQ-024 If BLANK_LZ=1, every zero digit above the most significant nonzero digit SHALL be blank, and digit 0 SHALL always be displayed.
REQ-025 On overflow, every digit SHALL show dash and overflow SHALL be 1; a subsequent non-overflowing conversion SHALL clear it.

Reset
REQ-026 reset_n=0 SHALL asynchronously force state IDLE, busy=0, done=0, overflow=0, counter=0, BCD register=0, and all seg_out digits blank (1111111).
REQ-027 Reset asserted mid-CONVERT SHALL abort the conversion with no done pulse, and the display SHALL remain blank after release.
REQ-028 After reset_n rises, the first load SHALL be accepted on the first rising edge at which it is sampled high.

Verification
REQ-029 The bench SHALL cover: defaults, load=1 for one cycle with value_in=157 -> done 9 cycles later; seg_out digits 2..0 = 1111001, 0010010, 1111000; overflow=0.
REQ-030 The bench SHALL cover: defaults, value_in=7 then value_in=0 -> digits {blank, blank, 1111000}, then {blank, blank, 1000000}; with BLANK_LZ=0 and value 7 -> {1000000, 1000000, 1111000}.
REQ-031 The bench SHALL cover: DIGITS=2, value_in=100 -> both digits 0111111 and overflow=1; then value_in=99 -> {0010000, 0010000} and overflow=0.
REQ-032 The bench SHALL cover: load 255, then load 12 pulsed during CONVERT -> the second load is ignored; the display shows 0100100 / 0010010 / 0010010 (255); exactly one done pulse.
REQ-033 The bench SHALL cover: reset_n low 4 cycles after load of 200 -> busy=0 immediately, no done pulse, all digits 1111111; a following load of 42 -> digits {blank, 0011001, 0100100}.
REQ-034 The bench SHALL cover: WIDTH=16, DIGITS=5, value_in=65535 -> done at 17 cycles; digits 4..0 = 0000010, 0010010, 0010010, 0110000, 0010010.
